// File: rtl/fetch_unit.sv
// Instruction fetch stage: issues imem reads under a credit limit, buffers responses in a
// prefetch FIFO, and handles decoder redirects. Optional FETCH_MISALIGN_CHECK_EN flags misaligned targets.
module fetch_unit #(
    parameter int unsigned            DATA_WIDTH = 32,
    parameter logic [DATA_WIDTH-1:0]  RESET_PC   = 32'h0000_0000,
    parameter int unsigned            FIFO_DEPTH = 2,
    parameter logic [DATA_WIDTH-1:0]  NOP_INSTR  = 32'h0000_0013
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    output logic                  imem_req_o,
    output logic [DATA_WIDTH-1:0] imem_addr_o,
    input  logic                  imem_gnt_i,
    input  logic                  imem_rvalid_i,
    input  logic [DATA_WIDTH-1:0] imem_rdata_i,
    input  logic                  pc_sel_i,
    input  logic [DATA_WIDTH-1:0] branch_target_i,
    input  logic                  id_ready_i,
    output logic                  instr_valid_o,
    output logic [DATA_WIDTH-1:0] instr_o,
    output logic [DATA_WIDTH-1:0] pc_o,
    output logic                  misalign_o
);

    localparam int unsigned PW = $clog2(FIFO_DEPTH);
    localparam int unsigned CW = PW + 1;
    localparam logic [DATA_WIDTH-1:0] INC = DATA_WIDTH'(4);

    typedef enum logic [0:0] {StRun, StWaitGnt} state_e;

    state_e                state_q, state_d;
    logic [DATA_WIDTH-1:0] fetch_pc_q, fetch_pc_d;
    logic [DATA_WIDTH-1:0] target_q, target_d;
    logic [DATA_WIDTH-1:0] resp_pc_q, resp_pc_d;
    logic [CW-1:0]         outst_q, outst_d;
    logic [CW-1:0]         discard_q, discard_d;
    logic                  active_q;

    logic [DATA_WIDTH-1:0] fifo_instr_q [FIFO_DEPTH];
    logic [DATA_WIDTH-1:0] fifo_pc_q    [FIFO_DEPTH];
    logic [PW-1:0]         wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]         count_q;

    logic                  gnt_acc, rv_acc, push, pop, fifo_empty, fifo_full, credit_ok;
    logic [DATA_WIDTH-1:0] target;

`ifdef FETCH_MISALIGN_CHECK_EN
    logic mis_q, mis_d, halt_q, halt_d;
    assign target = branch_target_i;
`else
    logic unused_target_lsb;
    assign target            = {branch_target_i[DATA_WIDTH-1:2], 2'b00};
    assign unused_target_lsb = ^branch_target_i[1:0];
`endif

    assign fifo_empty = (count_q == '0);
    assign fifo_full  = (count_q == CW'(FIFO_DEPTH));
    assign credit_ok  = ({1'b0, outst_q} + {1'b0, count_q}) < (CW + 1)'(FIFO_DEPTH);

`ifdef FETCH_MISALIGN_CHECK_EN
    assign imem_req_o = (state_q == StWaitGnt) ||
                        (state_q == StRun && active_q && credit_ok && !halt_q);
`else
    assign imem_req_o = (state_q == StWaitGnt) || (state_q == StRun && active_q && credit_ok);
`endif
    assign imem_addr_o = fetch_pc_q;

    assign gnt_acc = imem_req_o && imem_gnt_i;
    // A response with nothing outstanding (e.g. left over from before reset) is ignored.
    assign rv_acc  = imem_rvalid_i && (outst_q != '0);
    assign push    = rv_acc && (discard_q == '0) && !pc_sel_i;
    assign pop     = !fifo_empty && id_ready_i && !pc_sel_i;

    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        target_d   = target_q;
        resp_pc_d  = resp_pc_q;
        outst_d    = outst_q + CW'(gnt_acc) - CW'(rv_acc);
        discard_d  = discard_q - CW'(rv_acc && (discard_q != '0));
`ifdef FETCH_MISALIGN_CHECK_EN
        mis_d      = mis_q && !id_ready_i;
        halt_d     = halt_q;
`endif
        if (push) begin
            resp_pc_d = resp_pc_q + INC;
        end

        unique case (state_q)
            StRun: begin
                if (gnt_acc) begin
                    fetch_pc_d = fetch_pc_q + INC;
                end
            end
            StWaitGnt: begin
                // The granted request belongs to the old path; its data is dropped.
                if (gnt_acc) begin
                    state_d    = StRun;
                    fetch_pc_d = target_q;
                    resp_pc_d  = target_q;
                    discard_d  = discard_d + CW'(1);
                end
            end
            default: state_d = StRun;
        endcase

        if (pc_sel_i) begin
            discard_d = outst_q + CW'(gnt_acc) - CW'(rv_acc);
`ifdef FETCH_MISALIGN_CHECK_EN
            mis_d  = 1'b0;
            halt_d = 1'b0;
            if (|branch_target_i[1:0]) begin
                state_d  = StRun;
                target_d = target;
                mis_d    = 1'b1;
                halt_d   = 1'b1;
            end else
`endif
            if (imem_req_o && !imem_gnt_i) begin
                state_d  = StWaitGnt;
                target_d = target;
            end else begin
                state_d    = StRun;
                fetch_pc_d = target;
                resp_pc_d  = target;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= StRun;
            fetch_pc_q <= RESET_PC;
            target_q   <= RESET_PC;
            resp_pc_q  <= RESET_PC;
            outst_q    <= '0;
            discard_q  <= '0;
            active_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            target_q   <= target_d;
            resp_pc_q  <= resp_pc_d;
            outst_q    <= outst_d;
            discard_q  <= discard_d;
            active_q   <= 1'b1;
        end
    end

`ifdef FETCH_MISALIGN_CHECK_EN
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            mis_q  <= 1'b0;
            halt_q <= 1'b0;
        end else begin
            mis_q  <= mis_d;
            halt_q <= halt_d;
        end
    end
`endif

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                fifo_instr_q[i] <= NOP_INSTR;
                fifo_pc_q[i]    <= RESET_PC;
            end
        end else if (pc_sel_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) begin
                fifo_instr_q[wr_ptr_q] <= imem_rdata_i;
                fifo_pc_q[wr_ptr_q]    <= resp_pc_q;
                wr_ptr_q               <= wr_ptr_q + PW'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PW'(1);
            end
            count_q <= count_q + CW'(push) - CW'(pop);
        end
    end

    always_comb begin
        instr_valid_o = !fifo_empty;
        instr_o       = fifo_empty ? NOP_INSTR : fifo_instr_q[rd_ptr_q];
        pc_o          = fifo_pc_q[rd_ptr_q];
        misalign_o    = 1'b0;
`ifdef FETCH_MISALIGN_CHECK_EN
        if (mis_q) begin
            instr_valid_o = 1'b1;
            instr_o       = NOP_INSTR;
            pc_o          = target_q;
            misalign_o    = 1'b1;
        end
`endif
    end

    a_no_overflow: assert property (@(posedge clk_i) disable iff (!rst_ni)
        !(push && fifo_full && !pop));

endmodule

// File: tb/tb_fetch_unit.sv
// Directed self-checking bench for fetch_unit with a 1-cycle-latency imem responder.
module tb_fetch_unit;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic        imem_req_o;
    logic [31:0] imem_addr_o;
    logic        imem_gnt_i;
    logic        imem_rvalid_i;
    logic [31:0] imem_rdata_i;
    logic        pc_sel_i;
    logic [31:0] branch_target_i;
    logic        id_ready_i;
    logic        instr_valid_o;
    logic [31:0] instr_o;
    logic [31:0] pc_o;
    logic        misalign_o;

    int n_cmp = 0;
    int n_err = 0;

    logic [31:0] inflight [$];
    bit          model_en = 1'b1;
    bit          gnt_en   = 1'b1;
    bit          rv_en    = 1'b1;
    int          gcount   = 0;

    fetch_unit dut (
        .clk_i           (clk_i),
        .rst_ni          (rst_ni),
        .imem_req_o      (imem_req_o),
        .imem_addr_o     (imem_addr_o),
        .imem_gnt_i      (imem_gnt_i),
        .imem_rvalid_i   (imem_rvalid_i),
        .imem_rdata_i    (imem_rdata_i),
        .pc_sel_i        (pc_sel_i),
        .branch_target_i (branch_target_i),
        .id_ready_i      (id_ready_i),
        .instr_valid_o   (instr_valid_o),
        .instr_o         (instr_o),
        .pc_o            (pc_o),
        .misalign_o      (misalign_o)
    );

    always #5 clk_i = ~clk_i;

    function automatic logic [31:0] mem_data(input logic [31:0] a);
        return a ^ 32'hC0DE_0000;
    endfunction

    // Memory responder: acts 1 time unit after each falling edge.
    initial begin
        forever begin
            @(negedge clk_i);
            #1;
            if (model_en) begin
                if (!rst_ni) begin
                    inflight.delete();
                    imem_gnt_i    = 1'b0;
                    imem_rvalid_i = 1'b0;
                end else begin
                    if (rv_en && inflight.size() > 0) begin
                        imem_rvalid_i = 1'b1;
                        imem_rdata_i  = mem_data(inflight.pop_front());
                    end else begin
                        imem_rvalid_i = 1'b0;
                    end
                    imem_gnt_i = gnt_en;
                    if (gnt_en && imem_req_o) begin
                        inflight.push_back(imem_addr_o);
                        gcount++;
                    end
                end
            end
        end
    end

    task automatic do_reset();
        rst_ni          = 1'b0;
        pc_sel_i        = 1'b0;
        branch_target_i = '0;
        inflight.delete();
        gcount = 0;
        repeat (2) @(posedge clk_i);
        #1 rst_ni = 1'b1;
    endtask

    task automatic wait_valid(input int budget, output bit ok, output logic [31:0] pc,
                              output logic [31:0] ins);
        ok  = 1'b0;
        pc  = '0;
        ins = '0;
        for (int i = 0; i < budget && !ok; i++) begin
            @(negedge clk_i);
            if (instr_valid_o) begin
                ok  = 1'b1;
                pc  = pc_o;
                ins = instr_o;
            end
        end
    endtask

    task automatic test_reset();
        rst_ni = 1'b0;
        @(posedge clk_i);
        #1;
        n_cmp++; if (imem_req_o !== 1'b0) begin n_err++; $display("FAIL rst_req: got %b expected 0", imem_req_o); end
        n_cmp++; if (imem_addr_o !== 32'h0) begin n_err++; $display("FAIL rst_addr: got %h expected 0", imem_addr_o); end
        n_cmp++; if (instr_valid_o !== 1'b0) begin n_err++; $display("FAIL rst_valid: got %b expected 0", instr_valid_o); end
        n_cmp++; if (instr_o !== NOP) begin n_err++; $display("FAIL rst_instr: got %h expected %h", instr_o, NOP); end
        n_cmp++; if (pc_o !== 32'h0) begin n_err++; $display("FAIL rst_pc: got %h expected 0", pc_o); end
        n_cmp++; if (misalign_o !== 1'b0) begin n_err++; $display("FAIL rst_misalign: got %b expected 0", misalign_o); end
    endtask

    task automatic test_stream();
        bit ok;
        logic [31:0] pc, ins;
        gnt_en = 1'b1; rv_en = 1'b1; id_ready_i = 1'b1;
        do_reset();
        repeat (2) @(negedge clk_i);
        n_cmp++; if (imem_req_o !== 1'b1 || imem_addr_o !== 32'h0) begin
            n_err++; $display("FAIL stream_first_req: got req=%b addr=%h expected req=1 addr=0", imem_req_o, imem_addr_o); end
        repeat (2) @(negedge clk_i);
        n_cmp++; if (instr_valid_o !== 1'b1 || pc_o !== 32'h0 || instr_o !== mem_data(32'h0)) begin
            n_err++; $display("FAIL stream_latency: got v=%b pc=%h instr=%h expected v=1 pc=0 instr=%h",
                              instr_valid_o, pc_o, instr_o, mem_data(32'h0)); end
        for (int k = 1; k < 6; k++) begin
            wait_valid(8, ok, pc, ins);
            n_cmp++; if (!ok || pc !== 32'(4 * k) || ins !== mem_data(32'(4 * k))) begin
                n_err++; $display("FAIL stream_pc%0d: got ok=%b pc=%h instr=%h expected pc=%h", k, ok, pc, ins, 32'(4 * k)); end
        end
    endtask

    task automatic test_stall();
        id_ready_i = 1'b0; gnt_en = 1'b1; rv_en = 1'b1;
        do_reset();
        repeat (5) @(negedge clk_i);
        n_cmp++; if (instr_valid_o !== 1'b1 || pc_o !== 32'h0) begin
            n_err++; $display("FAIL stall_head_early: got v=%b pc=%h expected v=1 pc=0", instr_valid_o, pc_o); end
        repeat (3) @(negedge clk_i);
        n_cmp++; if (gcount !== 2) begin n_err++; $display("FAIL stall_grants: got %0d expected 2", gcount); end
        n_cmp++; if (imem_req_o !== 1'b0) begin n_err++; $display("FAIL stall_req: got %b expected 0", imem_req_o); end
        n_cmp++; if (instr_valid_o !== 1'b1 || pc_o !== 32'h0 || instr_o !== mem_data(32'h0)) begin
            n_err++; $display("FAIL stall_head_held: got v=%b pc=%h instr=%h expected pc=0", instr_valid_o, pc_o, instr_o); end
        id_ready_i = 1'b1;
        @(negedge clk_i);
        n_cmp++; if (instr_valid_o !== 1'b1 || pc_o !== 32'h4) begin
            n_err++; $display("FAIL stall_resume: got v=%b pc=%h expected v=1 pc=4", instr_valid_o, pc_o); end
    endtask

    task automatic test_redirect_outstanding();
        bit ok;
        logic [31:0] pc, ins;
        id_ready_i = 1'b1; gnt_en = 1'b1; rv_en = 1'b0;
        do_reset();
        repeat (4) @(negedge clk_i);
        n_cmp++; if (gcount !== 2) begin n_err++; $display("FAIL redir_outst: got %0d grants expected 2", gcount); end
        pc_sel_i = 1'b1; branch_target_i = 32'h100;
        @(negedge clk_i);
        pc_sel_i = 1'b0; rv_en = 1'b1;
        n_cmp++; if (instr_valid_o !== 1'b0) begin n_err++; $display("FAIL redir_flush: got %b expected 0", instr_valid_o); end
        wait_valid(12, ok, pc, ins);
        n_cmp++; if (!ok || pc !== 32'h100 || ins !== mem_data(32'h100)) begin
            n_err++; $display("FAIL redir_target: got ok=%b pc=%h instr=%h expected pc=100", ok, pc, ins); end
    endtask

    task automatic test_redirect_wait_gnt();
        bit ok;
        logic [31:0] pc, ins;
        id_ready_i = 1'b1; gnt_en = 1'b0; rv_en = 1'b1;
        do_reset();
        repeat (2) @(negedge clk_i);
        pc_sel_i = 1'b1; branch_target_i = 32'h200;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk_i);
            pc_sel_i = 1'b0;
            n_cmp++; if (imem_req_o !== 1'b1 || imem_addr_o !== 32'h0) begin
                n_err++; $display("FAIL waitgnt_hold%0d: got req=%b addr=%h expected req=1 addr=0", k, imem_req_o, imem_addr_o); end
        end
        gnt_en = 1'b1;
        @(negedge clk_i);
        n_cmp++; if (imem_req_o !== 1'b1 || imem_addr_o !== 32'h200) begin
            n_err++; $display("FAIL waitgnt_newaddr: got req=%b addr=%h expected req=1 addr=200", imem_req_o, imem_addr_o); end
        wait_valid(10, ok, pc, ins);
        n_cmp++; if (!ok || pc !== 32'h200 || ins !== mem_data(32'h200)) begin
            n_err++; $display("FAIL waitgnt_target: got ok=%b pc=%h instr=%h expected pc=200", ok, pc, ins); end
    endtask

    task automatic test_reset_mid();
        id_ready_i = 1'b1; gnt_en = 1'b1; rv_en = 1'b1;
        do_reset();
        repeat (5) @(negedge clk_i);
        #2 rst_ni = 1'b0;
        #1;
        n_cmp++; if (imem_req_o !== 1'b0 || imem_addr_o !== 32'h0) begin
            n_err++; $display("FAIL midrst_req: got req=%b addr=%h expected req=0 addr=0", imem_req_o, imem_addr_o); end
        n_cmp++; if (instr_valid_o !== 1'b0 || instr_o !== NOP || pc_o !== 32'h0 || misalign_o !== 1'b0) begin
            n_err++; $display("FAIL midrst_out: got v=%b instr=%h pc=%h mis=%b expected v=0 instr=%h pc=0 mis=0",
                              instr_valid_o, instr_o, pc_o, misalign_o, NOP); end
        model_en = 1'b0;
        imem_gnt_i = 1'b0; imem_rvalid_i = 1'b0;
        inflight.delete();
        @(posedge clk_i);
        #1 rst_ni = 1'b1;
        @(negedge clk_i);
        imem_rvalid_i = 1'b1; imem_rdata_i = 32'hBAD0_0BAD;
        @(negedge clk_i);
        imem_rvalid_i = 1'b0;
        n_cmp++; if (instr_valid_o !== 1'b0) begin n_err++; $display("FAIL midrst_late_rvalid: got v=%b expected 0", instr_valid_o); end
        @(negedge clk_i);
        n_cmp++; if (instr_valid_o !== 1'b0) begin n_err++; $display("FAIL midrst_late_rvalid2: got v=%b expected 0", instr_valid_o); end
        model_en = 1'b1;
    endtask

    task automatic test_wrap();
        bit ok;
        logic [31:0] pc, ins;
        id_ready_i = 1'b1; gnt_en = 1'b1; rv_en = 1'b1;
        do_reset();
        repeat (3) @(negedge clk_i);
        pc_sel_i = 1'b1; branch_target_i = 32'hFFFF_FFFC;
        @(negedge clk_i);
        pc_sel_i = 1'b0;
        wait_valid(10, ok, pc, ins);
        n_cmp++; if (!ok || pc !== 32'hFFFF_FFFC) begin
            n_err++; $display("FAIL wrap_top: got ok=%b pc=%h expected fffffffc", ok, pc); end
        wait_valid(10, ok, pc, ins);
        n_cmp++; if (!ok || pc !== 32'h0 || ins !== mem_data(32'h0)) begin
            n_err++; $display("FAIL wrap_zero: got ok=%b pc=%h instr=%h expected pc=0", ok, pc, ins); end
    endtask

    task automatic test_misalign();
        bit ok;
        logic [31:0] pc, ins;
        gnt_en = 1'b1; rv_en = 1'b1;
`ifdef FETCH_MISALIGN_CHECK_EN
        id_ready_i = 1'b0;
`else
        id_ready_i = 1'b1;
`endif
        do_reset();
        repeat (4) @(negedge clk_i);
        pc_sel_i = 1'b1; branch_target_i = 32'h102;
        @(negedge clk_i);
        pc_sel_i = 1'b0;
`ifdef FETCH_MISALIGN_CHECK_EN
        n_cmp++; if (instr_valid_o !== 1'b1 || instr_o !== NOP || pc_o !== 32'h102 || misalign_o !== 1'b1) begin
            n_err++; $display("FAIL mis_entry: got v=%b instr=%h pc=%h mis=%b expected v=1 instr=13 pc=102 mis=1",
                              instr_valid_o, instr_o, pc_o, misalign_o); end
        for (int k = 0; k < 3; k++) begin
            @(negedge clk_i);
            n_cmp++; if (imem_req_o !== 1'b0) begin n_err++; $display("FAIL mis_noreq%0d: got %b expected 0", k, imem_req_o); end
        end
`else
        n_cmp++; if (instr_valid_o !== 1'b0) begin n_err++; $display("FAIL align_flush: got %b expected 0", instr_valid_o); end
        wait_valid(12, ok, pc, ins);
        n_cmp++; if (!ok || pc !== 32'h100 || ins !== mem_data(32'h100) || misalign_o !== 1'b0) begin
            n_err++; $display("FAIL align_target: got ok=%b pc=%h instr=%h mis=%b expected pc=100 mis=0",
                              ok, pc, ins, misalign_o); end
`endif
    endtask

    initial begin
        pc_sel_i        = 1'b0;
        branch_target_i = '0;
        id_ready_i      = 1'b1;
        imem_gnt_i      = 1'b0;
        imem_rvalid_i   = 1'b0;
        imem_rdata_i    = '0;
        test_reset();
        test_stream();
        test_stall();
        test_redirect_outstanding();
        test_redirect_wait_gnt();
        test_reset_mid();
        test_wrap();
        test_misalign();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
